// File: rtl/karatsuba_pkg.sv
// Shared definitions for the Karatsuba sequential multiplier: FSM encoding
// and width helpers used to derive the half width and Booth operand width.
package karatsuba_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t M_LO    = 3'd1;
    localparam state_t M_HI    = 3'd2;
    localparam state_t M_MID   = 3'd3;
    localparam state_t COMBINE = 3'd4;
    localparam state_t DONE    = 3'd5;

    function automatic int half_w(input int w);
        return w / 2;
    endfunction

    // Two extra bits: one for the carry of the mid sums, one forced-zero sign bit.
    function automatic int mul_w(input int w);
        return w / 2 + 2;
    endfunction

endpackage

// File: rtl/karatsuba_combine.sv
// Purely combinational Karatsuba recombination: z1 = zm - z0 - z2, then
// p = z2*2^W + z1*2^H + z0, kept to 2W bits (the carry-out is always zero).
module karatsuba_combine
    import karatsuba_pkg::*;
#(
    parameter  int W  = 16,
    localparam int H  = half_w(W),
    localparam int ZW = 2 * H + 2
) (
    input  logic [2*H-1:0] z0_i,
    input  logic [2*H-1:0] z2_i,
    input  logic [ZW-1:0]  zm_i,
    output logic [2*W-1:0] p_o
);

    localparam int PW = 2 * W;

    logic [ZW-1:0] z1;

    assign z1  = zm_i - ZW'(z0_i) - ZW'(z2_i);
    assign p_o = (PW'(z2_i) << W) + (PW'(z1) << H) + PW'(z0_i);

endmodule

// File: rtl/karatsuba_seq_mul.sv
// Sequential unsigned WxW multiplier: one-level Karatsuba that reuses a single
// external Booth multiplier for the low, high and mid sub-products.
module karatsuba_seq_mul
    import karatsuba_pkg::*;
#(
    parameter  int W  = 16,
    localparam int H  = half_w(W),
    localparam int MW = mul_w(W)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_x,
    input  logic [W-1:0]    in_y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  out_p,
    output logic [MW-1:0]   mul_x,
    output logic [MW-1:0]   mul_y,
    input  logic [2*MW-1:0] mul_p
);

    localparam int ZW = 2 * H + 2;
    localparam int PH = 2 * H;

    state_t         state_q, state_d;
    logic [H-1:0]   xl_q, xh_q, yl_q, yh_q;
    logic [PH-1:0]  z0_q, z2_q;
    logic [ZW-1:0]  zm_q;
    logic [2*W-1:0] out_p_q;
    logic [2*W-1:0] prod;
    logic [H:0]     sum_x, sum_y;

    assign sum_x = {1'b0, xl_q} + {1'b0, xh_q};
    assign sum_y = {1'b0, yl_q} + {1'b0, yh_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = M_LO;
            M_LO:    state_d = M_HI;
            M_HI:    state_d = M_MID;
            M_MID:   state_d = COMBINE;
            COMBINE: state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_x     = '0;
        mul_y     = '0;
        case (state_q)
            IDLE:  in_ready = 1'b1;
            M_LO: begin
                mul_x = {2'b00, xl_q};
                mul_y = {2'b00, yl_q};
            end
            M_HI: begin
                mul_x = {2'b00, xh_q};
                mul_y = {2'b00, yh_q};
            end
            M_MID: begin
                mul_x = {1'b0, sum_x};
                mul_y = {1'b0, sum_y};
            end
            DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // mul_p is only looked at in the multiply states, so X from an idle Booth unit never leaks in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xl_q    <= '0;
            xh_q    <= '0;
            yl_q    <= '0;
            yh_q    <= '0;
            z0_q    <= '0;
            z2_q    <= '0;
            zm_q    <= '0;
            out_p_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        xl_q <= in_x[H-1:0];
                        xh_q <= in_x[W-1:H];
                        yl_q <= in_y[H-1:0];
                        yh_q <= in_y[W-1:H];
                    end
                end
                M_LO:    z0_q    <= PH'(mul_p);
                M_HI:    z2_q    <= PH'(mul_p);
                M_MID:   zm_q    <= ZW'(mul_p);
                COMBINE: out_p_q <= prod;
                default: ;
            endcase
        end
    end

    karatsuba_combine #(
        .W (W)
    ) u_combine (
        .z0_i (z0_q),
        .z2_i (z2_q),
        .zm_i (zm_q),
        .p_o  (prod)
    );

    assign out_p = out_p_q;

endmodule

// File: tb/tb_karatsuba_seq_mul.sv
// Self-checking bench for karatsuba_seq_mul: directed cases, backpressure,
// mid-operation reset, back-to-back throughput and random pairs vs x*y.
module tb_karatsuba_seq_mul;

    localparam int W  = 16;
    localparam int H  = W / 2;
    localparam int MW = H + 2;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_x;
    logic [W-1:0]    in_y;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  out_p;
    logic [MW-1:0]   mul_x;
    logic [MW-1:0]   mul_y;
    logic [2*MW-1:0] mul_p;

    int   checks;
    int   errors;
    logic msb_viol;

    karatsuba_seq_mul #(
        .W (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_p     (mul_p)
    );

    // External multiplier: operands are non-negative, so a plain product matches the Booth unit.
    assign mul_p = {{MW{1'b0}}, mul_x} * {{MW{1'b0}}, mul_y};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial msb_viol = 1'b0;
    always @(negedge clk) begin
        if (mul_x[MW-1] || mul_y[MW-1]) msb_viol = 1'b1;
    end

    function automatic logic [2*W-1:0] golden(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] a;
        logic [2*W-1:0] b;
        a = {{W{1'b0}}, x};
        b = {{W{1'b0}}, y};
        return a * b;
    endfunction

    // Drives one operand pair with out_ready assumed high; returns what it observed.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [2*W-1:0] p, output int lat, output logic v_after);
        int n;
        in_x = x;
        in_y = y;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_x = W'($urandom);
        in_y = W'($urandom);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        p = out_p;
        @(posedge clk); #1;
        v_after = out_valid;
        $display("op x=%h y=%h p=%h lat=%0d", x, y, p, lat);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_x = '0;
        in_y = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== '0 || mul_x !== '0 || mul_y !== '0) begin
            errors++;
            $display("FAIL reset_hold rdy=%b vld=%b p=%h mx=%h my=%h required rdy=1 vld=0 p=0 mx=0 my=0",
                     in_ready, out_valid, out_p, mul_x, mul_y);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== '0) begin
            errors++;
            $display("FAIL reset_release rdy=%b vld=%b p=%h required rdy=1 vld=0 p=0",
                     in_ready, out_valid, out_p);
        end
    endtask

    task automatic test_directed;
        logic [W-1:0]   xs [4];
        logic [W-1:0]   ys [4];
        logic [2*W-1:0] exp_p [4];
        logic [2*W-1:0] p;
        int             lat;
        logic           va;
        xs[0] = 16'h1234; ys[0] = 16'h5678; exp_p[0] = 32'h06260060;
        xs[1] = 16'hFFFF; ys[1] = 16'hFFFF; exp_p[1] = 32'hFFFE0001;
        xs[2] = 16'h0000; ys[2] = 16'hABCD; exp_p[2] = 32'h00000000;
        xs[3] = 16'h0001; ys[3] = 16'hABCD; exp_p[3] = 32'h0000ABCD;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_op(xs[i], ys[i], p, lat, va);
            checks++;
            if (p !== exp_p[i]) begin
                errors++;
                $display("FAIL directed_%0d product got %h required %h", i, p, exp_p[i]);
            end
            checks++;
            if (lat !== 5) begin
                errors++;
                $display("FAIL directed_%0d latency got %0d required 5", i, lat);
            end
            checks++;
            if (va !== 1'b0) begin
                errors++;
                $display("FAIL directed_%0d valid_width out_valid got %b required 0 one cycle later", i, va);
            end
        end
    endtask

    task automatic test_backpressure;
        int   n;
        logic held_ok;
        logic stray;
        logic [2*W-1:0] p;
        int   lat;
        logic va;
        out_ready = 1'b0;
        in_x = 16'h00FF;
        in_y = 16'h0100;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_x = 16'h1111;
        in_y = 16'h2222;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (out_p !== 32'h0000FF00) begin
            errors++;
            $display("FAIL bp_product got %h required 0000ff00", out_p);
        end
        held_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (out_valid !== 1'b1 || out_p !== 32'h0000FF00 || in_ready !== 1'b0
                || mul_x !== '0 || mul_y !== '0) held_ok = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (held_ok !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold stable got %b required 1 (vld=%b p=%h rdy=%b)",
                     held_ok, out_valid, out_p, in_ready);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
        end
        stray = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stray = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_stray_accept got %b required 0", stray);
        end
        do_op(16'h0003, 16'h0007, p, lat, va);
        checks++;
        if (p !== 32'd21) begin
            errors++;
            $display("FAIL bp_followup product got %h required %h", p, 32'd21);
        end
    endtask

    task automatic test_reset_mid_op;
        int   n;
        logic [MW-1:0] exp_mx;
        logic stray;
        logic [2*W-1:0] p;
        int   lat;
        logic va;
        out_ready = 1'b1;
        in_x = 16'h1234;
        in_y = 16'h5678;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_mx = MW'(16'h34) + MW'(16'h12);
        checks++;
        if (mul_x !== exp_mx) begin
            errors++;
            $display("FAIL mid_operand mul_x got %h required %h", mul_x, exp_mx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== '0 || mul_x !== '0 || mul_y !== '0) begin
            errors++;
            $display("FAIL async_reset rdy=%b vld=%b p=%h mx=%h my=%h required rdy=1 vld=0 p=0 mx=0 my=0",
                     in_ready, out_valid, out_p, mul_x, mul_y);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid !== 1'b0) stray = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard stray out_valid got %b required 0", stray);
        end
        do_op(16'd3, 16'd5, p, lat, va);
        checks++;
        if (p !== 32'd15) begin
            errors++;
            $display("FAIL after_reset product got %h required %h", p, 32'd15);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0]   xs [3];
        logic [W-1:0]   ys [3];
        logic [2*W-1:0] got [3];
        int             acc_cyc [3];
        int             nacc;
        int             nres;
        logic           took;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            xs[i] = W'($urandom);
            ys[i] = W'($urandom);
            got[i] = '0;
            acc_cyc[i] = 0;
        end
        nacc = 0;
        nres = 0;
        in_x = xs[0];
        in_y = ys[0];
        in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            took = in_valid && in_ready;
            if (out_valid && nres < 3) begin
                got[nres] = out_p;
                nres++;
            end
            if (took && nacc < 3) begin
                acc_cyc[nacc] = c;
                nacc++;
            end
            @(posedge clk); #1;
            if (took) begin
                if (nacc < 3) begin
                    in_x = xs[nacc];
                    in_y = ys[nacc];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (nacc !== 3 || nres !== 3) begin
            errors++;
            $display("FAIL b2b_counts accepts=%0d results=%0d required 3 and 3", nacc, nres);
        end
        checks++;
        if (acc_cyc[1] - acc_cyc[0] !== 6 || acc_cyc[2] - acc_cyc[1] !== 6) begin
            errors++;
            $display("FAIL b2b_interval got %0d,%0d required 6,6",
                     acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
        end
        for (int i = 0; i < 3; i++) begin
            $display("b2b x=%h y=%h p=%h", xs[i], ys[i], got[i]);
            checks++;
            if (got[i] !== golden(xs[i], ys[i])) begin
                errors++;
                $display("FAIL b2b_product_%0d got %h required %h", i, got[i], golden(xs[i], ys[i]));
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        logic [2*W-1:0] p;
        int             lat;
        logic           va;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            case (i % 8)
                0:       begin x = 16'hFFFF;       y = W'($urandom); end
                1:       begin x = W'($urandom);   y = 16'hFF00;     end
                default: begin x = W'($urandom);   y = W'($urandom); end
            endcase
            do_op(x, y, p, lat, va);
            checks++;
            if (p !== golden(x, y) || lat !== 5) begin
                errors++;
                $display("FAIL random_%0d x=%h y=%h got p=%h lat=%0d required p=%h lat=5",
                         i, x, y, p, lat, golden(x, y));
            end
        end
        checks++;
        if (msb_viol !== 1'b0) begin
            errors++;
            $display("FAIL booth_msb mul_x/mul_y top bit seen set=%b required 0", msb_viol);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
